digit_scan_module: RTL
======================

# digit_scan_module

Six-digit multiplexed seven-segment display driver. Consumes the six BCD digits from the binary-to-BCD stage (`dat_1` = units ... `dat_6` = hundred-thousands) and drives the board's common-anode display via shared segment lines and per-digit select lines. It snapshots the digits once per scan frame so the display never tears mid-frame, and it inserts dead time between digits to suppress ghosting.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot, 1 ms at 50 MHz. Must be at least 2.
- `DEAD_CYCLES`, 16: cycles at the start of each slot with every select inactive. Must satisfy 0 <= `DEAD_CYCLES` < `SCAN_DIV`.
- `SEG_ACTIVE_LOW`, 1: 1 means `seg_o` bits are active-low.
- `SEL_ACTIVE_LOW`, 1: 1 means `sel_o` bits are active-low.
- `clk_i` input 1: system clock, the only clock.
- `rst_i` input 1: asynchronous, active-low reset.
- `dat_1_i` ... `dat_6_i` input 4 each: BCD digits; `dat_1_i` is the units digit.
- `dp_i` input 6: decimal-point enable per digit; bit k belongs to `dat_(k+1)_i`.
- `seg_o` output 8: bit 7 = dp; bits 6:0 = segments g..a.
- `sel_o` output 6: digit select; bit k drives `dat_(k+1)`.
- `frame_o` output 1: one-cycle pulse each time a new snapshot is loaded.

## Operation
- **Prescaler `cnt`:** counts 0..`SCAN_DIV`-1 and wraps. A slot tick occurs when `cnt` = `SCAN_DIV`-1.
- **Digit index `idx`:** runs 0..5 and advances on each slot tick, wrapping 5 -> 0. Scan order is units first.
- **Snapshot:** on the tick where `idx` wraps 5 -> 0, all six digits and `dp_i` are captured into shadow registers, and `frame_o` is asserted for the following cycle. Between snapshots, input changes have no effect on the outputs.
- **Decode:** shadow value 0-9 maps to the standard pattern (active-high g..a): 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F. Values 10-15 give all segments off.
- **Segment bits:** bit 7 = shadow dp of the current digit. The whole byte is inverted when `SEG_ACTIVE_LOW` = 1.
- **Select during dead time:** while `cnt` < `DEAD_CYCLES`, all selects are inactive and `seg_o` is all-off.
- **Select during the rest of the slot:** only `sel_o[idx]` is active; polarity is set by `SEL_ACTIVE_LOW`.
- **Reset values:**
  - `cnt`, `idx`, shadows and `frame_o` = 0.
  - `sel_o` all inactive: 6'h3F with defaults.
  - `seg_o` all off: 8'hFF with defaults.
- **Reset mid-slot:** outputs go to their reset values immediately, without waiting for a clock edge. After release, scanning restarts at `idx` 0 with a zero shadow, and the first snapshot loads after six slots.

## Timing
- `seg_o`, `sel_o` and `frame_o` are registered. They reflect the `cnt`/`idx`/shadow state of the previous edge, so there is a fixed one-cycle latency.
- Each digit is active for `SCAN_DIV`-`DEAD_CYCLES` cycles per slot. A frame lasts 6·`SCAN_DIV` cycles.
- Worst-case latency from an input change to its display is 2 frames plus 1 cycle.
- The snapshot load and the `idx` wrap happen on the same edge. The new frame's first slot (`idx` 0) displays the new snapshot.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:** shadow digit k (k >= 1) has segments g..a forced off when it and every higher shadow digit are 0. Digit 0 is never blanked. The dp bit is unaffected by blanking.
- **`LEADING_ZERO_BLANK_EN` undefined:** all six digits always display.

## Structure
- **Shared package/include `digit_scan_pkg`:**
  - `NUM_DIGITS` = 6.
  - The ten-entry seven-segment pattern constant table.
  - Segment bit-position constants.
- **Sub-module `seg7_decode`:** combinational 4-bit -> 7-bit active-high pattern, with all-off for values above 9. Polarity inversion and blanking stay in the top level.

## Test plan
Bench parameters: `SCAN_DIV` = 8, `DEAD_CYCLES` = 2, default polarities.
- **Reset:** hold `rst_i` low -> `sel_o` = 3F, `seg_o` = FF, `frame_o` = 0. Assert `rst_i` mid-slot while a digit is lit -> outputs return to 3F/FF with no clock edge.
- **Full scan:** digits 1..6 = 1,2,3,4,5,6 and `dp_i` = 0, after the first `frame_o`.
  - `sel_o` steps through 3E, 3D, 3B, 37, 2F, 1F.
  - Each select is active for 6 cycles, preceded by 2 cycles of 3F/FF.
  - `seg_o` steps through F9, A4, B0, 99, 92, 82.
- **Mid-frame change:** change `dat_1_i` 1 -> 7 while `idx` = 2 -> units still shows F9 until after the next `frame_o`, then F8.
- **Decimal point and invalid code:** `dp_i` = 6'b000010 with `dat_2_i` = 4'hA -> digit 2 `seg_o` = 7F (dp only); other digits keep bit 7 = 1.
- **Leading-zero blanking:** value 000042 with `LEADING_ZERO_BLANK_EN` -> digits 3-6 FF, digit 2 = 99, digit 1 = A4. Without the macro, digits 3-6 = C0. All-zero input with the macro -> digit 1 = C0, digits 2-6 = FF.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared constants for the six-digit seven-segment scan driver:
// digit count, segment bit positions and the BCD pattern table.
package digit_scan_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SEG_BYTE_W = 8;
  localparam int unsigned BCD_MAX    = 9;

  // Bit positions inside the segment byte
  localparam int unsigned SEG_A_BIT  = 0;
  localparam int unsigned SEG_G_BIT  = 6;
  localparam int unsigned SEG_DP_BIT = 7;

  // Active-high g..a patterns for 0-9
  localparam logic [SEG_W-1:0] SEG7_TABLE [BCD_MAX+1] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high seven-segment pattern; codes above 9 are blank.
module seg7_decode
  import digit_scan_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] pat
);

  always_comb begin
    pat = '0;
    if (bcd <= BCD_W'(BCD_MAX)) begin
      pat = SEG7_TABLE[bcd];
    end
  end

endmodule

// File: rtl/digit_scan_module.sv
// Six-digit multiplexed seven-segment driver with per-frame snapshot and dead time.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module digit_scan_module
  import digit_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] dat_1_i,
  input  logic [3:0] dat_2_i,
  input  logic [3:0] dat_3_i,
  input  logic [3:0] dat_4_i,
  input  logic [3:0] dat_5_i,
  input  logic [3:0] dat_6_i,
  input  logic [5:0] dp_i,
  output logic [7:0] seg_o,
  output logic [5:0] sel_o,
  output logic       frame_o
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_BYTE_W-1:0] SEG_OFF  = {SEG_BYTE_W{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [BCD_W-1:0]      shadow_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic [BCD_W-1:0]      dat_c [NUM_DIGITS];
  logic                  tick_c;
  logic                  wrap_c;
  logic                  dead_c;
  logic [NUM_DIGITS-1:0] blank_c;
  logic [BCD_W-1:0]      cur_dig_c;
  logic [SEG_W-1:0]      cur_pat_c;
  logic [SEG_BYTE_W-1:0] seg_raw_c;
  logic [NUM_DIGITS-1:0] sel_on_c;
  logic [SEG_BYTE_W-1:0] seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // Gather the input digits into an array indexed like the shadow
  always_comb begin
    dat_c[0] = dat_1_i;
    dat_c[1] = dat_2_i;
    dat_c[2] = dat_3_i;
    dat_c[3] = dat_4_i;
    dat_c[4] = dat_5_i;
    dat_c[5] = dat_6_i;
  end

  // Slot prescaler and digit index advance
  always_comb begin
    tick_c  = (cnt == CNT_LAST);
    wrap_c  = tick_c && (idx == IDX_LAST);
    cnt_nxt = tick_c ? '0 : cnt + CNT_W'(1);
    idx_nxt = idx;
    if (wrap_c) begin
      idx_nxt = '0;
    end else if (tick_c) begin
      idx_nxt = idx + IDX_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks when it and everything above it is zero; units never blank
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank_c  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (shadow_dig[k] == '0);
      blank_c[k] = zero_run;
    end
  end
`else
  assign blank_c = '0;
`endif

  assign cur_dig_c = shadow_dig[idx];

  seg7_decode u_decode (
    .bcd (cur_dig_c),
    .pat (cur_pat_c)
  );

  // Next output values from the current slot state
  always_comb begin
    seg_raw_c = '0;
    sel_on_c  = '0;
    seg_nxt   = SEG_OFF;
    sel_nxt   = SEL_OFF;
    dead_c    = (cnt < CNT_DEAD);
    seg_raw_c[SEG_DP_BIT]            = shadow_dp[idx];
    seg_raw_c[SEG_G_BIT:SEG_A_BIT]   = blank_c[idx] ? '0 : cur_pat_c;
    sel_on_c[idx]                    = 1'b1;
    if (!dead_c) begin
      seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw_c : seg_raw_c;
      sel_nxt = (SEL_ACTIVE_LOW != 0) ? ~sel_on_c  : sel_on_c;
    end
  end

  // Scan state and frame snapshot
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= '0;
      idx       <= '0;
      shadow_dp <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_dig[k] <= '0;
      end
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (wrap_c) begin
        shadow_dp <= dp_i;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          shadow_dig[k] <= dat_c[k];
        end
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      seg_o   <= SEG_OFF;
      sel_o   <= SEL_OFF;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= seg_nxt;
      sel_o   <= sel_nxt;
      frame_o <= wrap_c;
    end
  end

endmodule
